// File: rtl/map_compose_pkg.sv
// Shared defaults and FSM encoding for the map composer.
// Included by map_compose and spr_overlay.
package map_compose_pkg;

    localparam int MAP_W_DEF     = 13;
    localparam int MAP_H_DEF     = 13;
    localparam int GRID_BITS_DEF = 4;
    localparam int TILE_BITS_DEF = 16;
    localparam int ADDR_BITS_DEF = 19;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WAIT = 2'd2,
        S_EMIT = 2'd3
    } state_e;

endpackage

// File: rtl/map_compose_spr_overlay.sv
// Priority match of the current grid cell against the sprite channels.
// The lowest-index enabled channel on the cell wins.
module spr_overlay
    import map_compose_pkg::*;
#(
    parameter int NUM_SPR   = 4,
    parameter int GRID_BITS = GRID_BITS_DEF,
    parameter int TILE_BITS = TILE_BITS_DEF,
    parameter int MAP_W     = MAP_W_DEF,
    parameter int MAP_H     = MAP_H_DEF
) (
    input  logic [GRID_BITS-1:0]         x_i,
    input  logic [GRID_BITS-1:0]         y_i,
    input  logic [NUM_SPR-1:0]           en_i,
    input  logic [NUM_SPR*GRID_BITS-1:0] sx_i,
    input  logic [NUM_SPR*GRID_BITS-1:0] sy_i,
    input  logic [NUM_SPR*TILE_BITS-1:0] st_i,
    output logic                         hit_o,
    output logic [TILE_BITS-1:0]         tile_o
);

    localparam logic [GRID_BITS:0] X_LIM = (GRID_BITS+1)'(MAP_W);
    localparam logic [GRID_BITS:0] Y_LIM = (GRID_BITS+1)'(MAP_H);

    logic [GRID_BITS-1:0] sx;
    logic [GRID_BITS-1:0] sy;

    // Walk from the highest channel down so the lowest match overwrites.
    always_comb begin
        hit_o  = 1'b0;
        tile_o = '0;
        sx     = '0;
        sy     = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            sx = sx_i[i*GRID_BITS +: GRID_BITS];
            sy = sy_i[i*GRID_BITS +: GRID_BITS];
            if (en_i[i] && sx == x_i && sy == y_i &&
                {1'b0, sx} < X_LIM && {1'b0, sy} < Y_LIM) begin
                hit_o  = 1'b1;
                tile_o = st_i[i*TILE_BITS +: TILE_BITS];
            end
        end
    end

endmodule

// File: rtl/map_compose.sv
// Frame scanner: reads the tile map from BRAM and overlays sprites.
// Define MAP_ANIM_EN to flip bit 0 of sprite ids on alternate frames.
module map_compose
    import map_compose_pkg::*;
#(
    parameter int MAP_W     = MAP_W_DEF,
    parameter int MAP_H     = MAP_H_DEF,
    parameter int GRID_BITS = GRID_BITS_DEF,
    parameter int NUM_SPR   = 4,
    parameter int TILE_BITS = TILE_BITS_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int BRAM_LAT  = 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic [ADDR_BITS-1:0]         map_id,
    input  logic [NUM_SPR-1:0]           spr_en,
    input  logic [NUM_SPR*GRID_BITS-1:0] spr_x,
    input  logic [NUM_SPR*GRID_BITS-1:0] spr_y,
    input  logic [NUM_SPR*TILE_BITS-1:0] spr_tile,
    output logic [ADDR_BITS-1:0]         bram_addr,
    input  logic [TILE_BITS-1:0]         bram_data,
    output logic                         tile_valid,
    input  logic                         tile_ready,
    output logic [TILE_BITS-1:0]         tile_id,
    output logic [GRID_BITS-1:0]         tile_x,
    output logic [GRID_BITS-1:0]         tile_y,
    output logic                         busy,
    output logic                         done
);

    localparam logic [ADDR_BITS-1:0] CELLS  = ADDR_BITS'(MAP_W * MAP_H);
    localparam logic [GRID_BITS-1:0] X_LAST = GRID_BITS'(MAP_W - 1);
    localparam logic [GRID_BITS-1:0] Y_LAST = GRID_BITS'(MAP_H - 1);
    localparam logic [1:0]           W_LAST = 2'(BRAM_LAT - 1);

    state_e                       state_q;
    logic [GRID_BITS-1:0]         x_q;
    logic [GRID_BITS-1:0]         y_q;
    logic [1:0]                   wcnt_q;
    logic [ADDR_BITS-1:0]         addr_q;
    logic                         valid_q;
    logic [TILE_BITS-1:0]         id_q;
    logic [GRID_BITS-1:0]         tx_q;
    logic [GRID_BITS-1:0]         ty_q;
    logic                         busy_q;
    logic                         done_q;
    logic [NUM_SPR-1:0]           en_q;
    logic [NUM_SPR*GRID_BITS-1:0] sx_q;
    logic [NUM_SPR*GRID_BITS-1:0] sy_q;
    logic [NUM_SPR*TILE_BITS-1:0] st_q;

    logic [ADDR_BITS-1:0] base_d;
    logic                 hit;
    logic [TILE_BITS-1:0] spr_id;
    logic [TILE_BITS-1:0] anim;
    logic [TILE_BITS-1:0] tile_d;
    logic                 last_acc;

    assign base_d   = map_id * CELLS;
    assign last_acc = (state_q == S_EMIT) && tile_ready &&
                      (x_q == X_LAST) && (y_q == Y_LAST);

    spr_overlay #(
        .NUM_SPR  (NUM_SPR),
        .GRID_BITS(GRID_BITS),
        .TILE_BITS(TILE_BITS),
        .MAP_W    (MAP_W),
        .MAP_H    (MAP_H)
    ) u_ovl (
        .x_i   (x_q),
        .y_i   (y_q),
        .en_i  (en_q),
        .sx_i  (sx_q),
        .sy_i  (sy_q),
        .st_i  (st_q),
        .hit_o (hit),
        .tile_o(spr_id)
    );

`ifdef MAP_ANIM_EN
    logic phase_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q <= 1'b0;
        end else if (last_acc) begin
            phase_q <= ~phase_q;
        end
    end

    assign anim = {{(TILE_BITS-1){1'b0}}, phase_q};
`else
    assign anim = '0;
`endif

    always_comb begin
        tile_d = bram_data;
        if (hit) begin
            tile_d = spr_id ^ anim;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            st_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    // busy stays up through the done cycle
                    if (done_q) begin
                        busy_q <= 1'b0;
                    end
                    if (start && !busy_q) begin
                        en_q    <= spr_en;
                        sx_q    <= spr_x;
                        sy_q    <= spr_y;
                        st_q    <= spr_tile;
                        x_q     <= '0;
                        y_q     <= '0;
                        addr_q  <= base_d;
                        busy_q  <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    wcnt_q  <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (wcnt_q == W_LAST) begin
                        id_q    <= tile_d;
                        tx_q    <= x_q;
                        ty_q    <= y_q;
                        valid_q <= 1'b1;
                        state_q <= S_EMIT;
                    end else begin
                        wcnt_q <= wcnt_q + 2'd1;
                    end
                end
                S_EMIT: begin
                    if (tile_ready) begin
                        valid_q <= 1'b0;
                        if (last_acc) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            if (x_q == X_LAST) begin
                                x_q <= '0;
                                y_q <= y_q + GRID_BITS'(1);
                            end else begin
                                x_q <= x_q + GRID_BITS'(1);
                            end
                            addr_q  <= addr_q + ADDR_BITS'(1);
                            state_q <= S_READ;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bram_addr  = addr_q;
    assign tile_valid = valid_q;
    assign tile_id    = id_q;
    assign tile_x     = tx_q;
    assign tile_y     = ty_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_map_compose.sv
// Scoreboard bench for map_compose: queued expectations, negedge monitor.
module tb_map_compose;

`ifdef MAP_ANIM_EN
    localparam int ANIM = 1;
`else
    localparam int ANIM = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [18:0] map_id = '0;
    logic [3:0]  spr_en = '0;
    logic [15:0] spr_x = '0;
    logic [15:0] spr_y = '0;
    logic [63:0] spr_tile = '0;
    logic [18:0] bram_addr;
    logic [15:0] bram_data = '0;
    logic        tile_valid;
    logic        tile_ready = 1'b1;
    logic [15:0] tile_id;
    logic [3:0]  tile_x;
    logic [3:0]  tile_y;
    logic        busy;
    logic        done;

    map_compose dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .map_id    (map_id),
        .spr_en    (spr_en),
        .spr_x     (spr_x),
        .spr_y     (spr_y),
        .spr_tile  (spr_tile),
        .bram_addr (bram_addr),
        .bram_data (bram_data),
        .tile_valid(tile_valid),
        .tile_ready(tile_ready),
        .tile_id   (tile_id),
        .tile_x    (tile_x),
        .tile_y    (tile_y),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // One-cycle BRAM whose contents are the low address bits
    always @(posedge clk) bram_data <= bram_addr[15:0];

    typedef struct {
        int x;
        int y;
        int id;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int checks = 0;
    int errors = 0;
    int acc_total = 0;
    int stall_cyc = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_acc = -1;
    int exp_phase = 0;
    int first_id = -1;
    int last_id = -1;
    int mid_id = -1;
    bit thr_chk = 0;
    bit hold = 0;
    logic [15:0] h_id;
    logic [3:0]  h_x;
    logic [3:0]  h_y;

    int s_en[4];
    int sx[4];
    int sy[4];
    int st[4];

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rstn) begin
            hold = 0;
            last_acc = -1;
        end else begin
            if (done) begin
                done_cnt++;
                last_acc = -1;
            end
            if (tile_valid) begin
                if (hold) begin
                    check("hold_id", int'(tile_id), int'(h_id));
                    check("hold_x", int'(tile_x), int'(h_x));
                    check("hold_y", int'(tile_y), int'(h_y));
                end
                if (tile_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_tile: got (%0d,%0d) expected none",
                                 tile_x, tile_y);
                    end else begin
                        e = sb.pop_front();
                        check("tile_x", int'(tile_x), e.x);
                        check("tile_y", int'(tile_y), e.y);
                        check("tile_id", int'(tile_id), e.id);
                    end
                    if (thr_chk && last_acc >= 0)
                        check("interval", cyc - last_acc, 3);
                    if (tile_x == 0 && tile_y == 0) first_id = int'(tile_id);
                    if (tile_x == 12 && tile_y == 12) last_id = int'(tile_id);
                    if (tile_x == 3 && tile_y == 4) mid_id = int'(tile_id);
                    last_acc = cyc;
                    acc_total++;
                    hold = 0;
                end else begin
                    stall_cyc++;
                    hold = 1;
                    h_id = tile_id;
                    h_x = tile_x;
                    h_y = tile_y;
                end
            end else if (hold) begin
                check("valid_held", 0, 1);
                hold = 0;
            end
        end
    end

    task automatic apply_spr();
        for (int i = 0; i < 4; i++) begin
            spr_en[i] = (s_en[i] != 0);
            spr_x[i*4 +: 4] = 4'(sx[i]);
            spr_y[i*4 +: 4] = 4'(sy[i]);
            spr_tile[i*16 +: 16] = 16'(st[i]);
        end
    endtask

    task automatic clr_spr();
        for (int i = 0; i < 4; i++) begin
            s_en[i] = 0;
            sx[i] = 0;
            sy[i] = 0;
            st[i] = 0;
        end
    endtask

    task automatic push_frame(int mp);
        exp_t t;
        bit   found;
        for (int y = 0; y < 13; y++) begin
            for (int x = 0; x < 13; x++) begin
                t.x = x;
                t.y = y;
                t.id = (mp * 169 + y * 13 + x) & 16'hFFFF;
                found = 0;
                for (int i = 0; i < 4; i++) begin
                    if (!found && s_en[i] != 0 && sx[i] == x && sy[i] == y) begin
                        t.id = st[i] ^ (ANIM != 0 ? exp_phase : 0);
                        found = 1;
                    end
                end
                sb.push_back(t);
            end
        end
        exp_phase ^= 1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(string nm, int base);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 3000);
        if (!done) begin
            check({nm, "_timeout"}, 0, 1);
        end else begin
            check({nm, "_busy_at_done"}, int'(busy), 1);
            check({nm, "_tiles"}, acc_total - base, 169);
            check({nm, "_sb_empty"}, sb.size(), 0);
            @(negedge clk);
            check({nm, "_busy_after"}, int'(busy), 0);
            check({nm, "_done_pulse"}, int'(done), 0);
        end
    endtask

    task automatic run_frame(string nm, int mp);
        int base;
        apply_spr();
        map_id = 19'(mp);
        push_frame(mp);
        base = acc_total;
        pulse_start();
        wait_done(nm, base);
    endtask

    task automatic wait_acc(int target);
        int n;
        n = 0;
        while (acc_total < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (acc_total < target) check("wait_acc_timeout", acc_total, target);
    endtask

    task automatic check_reset_outs(string nm);
        check({nm, "_valid"}, int'(tile_valid), 0);
        check({nm, "_done"}, int'(done), 0);
        check({nm, "_busy"}, int'(busy), 0);
        check({nm, "_addr"}, int'(bram_addr), 0);
        check({nm, "_id"}, int'(tile_id), 0);
        check({nm, "_x"}, int'(tile_x), 0);
        check({nm, "_y"}, int'(tile_y), 0);
    endtask

    initial begin
        int base;
        int dc;
        int ph;
        int n;
        bit seen;

        clr_spr();
        apply_spr();
        repeat (3) @(posedge clk);
        #1 check_reset_outs("rst");
        rstn = 1'b1;

        // Plain map 2, full-rate throughput
        thr_chk = 1;
        dc = done_cnt;
        run_frame("plain", 2);
        thr_chk = 0;
        check("plain_first_id", first_id, 338);
        check("plain_last_id", last_id, 506);
        check("plain_done_cnt", done_cnt - dc, 1);

        // Overlapping sprites: lowest channel wins
        s_en[0] = 1; sx[0] = 3; sy[0] = 4; st[0] = 'h10;
        s_en[1] = 1; sx[1] = 13; sy[1] = 0; st[1] = 'h77;
        s_en[2] = 1; sx[2] = 3; sy[2] = 4; st[2] = 'h20;
        s_en[3] = 0; sx[3] = 3; sy[3] = 4; st[3] = 'h30;
        ph = (ANIM != 0) ? exp_phase : 0;
        run_frame("prio", 0);
        check("prio_ch0", mid_id, 'h10 ^ ph);
        s_en[0] = 0;
        ph = (ANIM != 0) ? exp_phase : 0;
        run_frame("prio2", 0);
        check("prio_ch2", mid_id, 'h20 ^ ph);

        // Back-pressure at tile (5,0)
        clr_spr();
        apply_spr();
        map_id = 19'd1;
        push_frame(1);
        base = acc_total;
        pulse_start();
        wait_acc(base + 5);
        @(posedge clk);
        #1 tile_ready = 1'b0;
        n = 0;
        while (!tile_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_seen", int'(tile_valid), 1);
        dc = stall_cyc;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 tile_ready = 1'b1;
        check("stall_cycles", stall_cyc - dc, 5);
        wait_done("stall", base);

        // Mid-scan start and sprite changes are ignored
        s_en[1] = 1; sx[1] = 0; sy[1] = 1; st[1] = 'h33;
        apply_spr();
        map_id = 19'd3;
        push_frame(3);
        base = acc_total;
        pulse_start();
        wait_acc(base + 20);
        clr_spr();
        s_en[0] = 1; sx[0] = 5; sy[0] = 5; st[0] = 'h99;
        apply_spr();
        map_id = 19'd5;
        pulse_start();
        wait_done("midstart", base);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (tile_valid || busy) seen = 1;
        end
        check("midstart_quiet", int'(seen), 0);

        // Reset in the middle of a frame
        clr_spr();
        apply_spr();
        map_id = 19'd0;
        push_frame(0);
        base = acc_total;
        pulse_start();
        wait_acc(base + 50);
        @(posedge clk);
        #1 rstn = 1'b0;
        #1 check_reset_outs("midrst");
        sb.delete();
        exp_phase = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Two frames with a sprite at (0,0) after reset
        s_en[0] = 1; sx[0] = 0; sy[0] = 0; st[0] = 'h10;
        first_id = -1;
        run_frame("anim1", 1);
        check("anim1_id", first_id, 'h10);
        first_id = -1;
        run_frame("anim2", 1);
        check("anim2_id", first_id, (ANIM != 0) ? 'h11 : 'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/map_compose.md
MAP_COMPOSE -- requirements
Module: map_compose

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- MAP_W, 13, grid width in tiles
- MAP_H, 13, grid height in tiles
- GRID_BITS, 4, width of one grid coordinate
- NUM_SPR, 4, number of sprite overlay channels
- TILE_BITS, 16, tile id width
- ADDR_BITS, 19, BRAM address width
- BRAM_LAT, 1, BRAM read latency in cycles (1..3)
REQ-002 Ports (name, direction, width, meaning); one clock, reset asynchronous active-low:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin one frame scan
- map_id  in  ADDR_BITS  map index
- spr_en  in  NUM_SPR  per-channel enable
- spr_x  in  NUM_SPR*GRID_BITS  flattened sprite columns, channel 0 in LSBs
- spr_y  in  NUM_SPR*GRID_BITS  flattened sprite rows
- spr_tile  in  NUM_SPR*TILE_BITS  flattened sprite tile ids
- bram_addr  out  ADDR_BITS  map BRAM read address
- bram_data  in  TILE_BITS  map BRAM read data
- tile_valid  out  1  tile output valid
- tile_ready  in  1  renderer accepts tile
- tile_id  out  TILE_BITS  composed tile id
- tile_x  out  GRID_BITS  column of tile
- tile_y  out  GRID_BITS  row of tile
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse after last tile accepted

Function
REQ-003 FSM states IDLE, READ, WAIT, EMIT; IDLE->READ on start; READ->WAIT; WAIT->EMIT after BRAM_LAT cycles counted from READ; EMIT->READ on accept if cells remain, else ->IDLE.
REQ-004 On start in IDLE, map_id, spr_en, spr_x, spr_y, spr_tile are snapshotted; input changes during a scan have no effect until the next start.
REQ-005 start while busy=1 is ignored.
REQ-006 Scan order is row-major: x 0..MAP_W-1 inner, y 0..MAP_H-1 outer; exactly MAP_W*MAP_H tiles per frame.
REQ-007 bram_addr = map_id*MAP_W*MAP_H + y*MAP_W + x, truncated to ADDR_BITS, driven and held stable from READ through WAIT.
REQ-008 Overlay: the lowest-index enabled channel with (spr_x,spr_y)==(x,y) replaces bram_data; if none matches, tile_id = bram_data. Coordinates >= MAP_W/MAP_H never match.
REQ-009 BRAM data is captured exactly BRAM_LAT cycles after the address is presented in READ.
REQ-010 In EMIT, tile_valid=1 and tile_id/tile_x/tile_y are held stable until tile_valid&&tile_ready; tile_valid never deasserts without acceptance.
REQ-011 With tile_ready held high, one tile is accepted every BRAM_LAT+2 cycles.
REQ-012 done pulses the cycle after the final acceptance; busy=1 from the cycle after start until the cycle done pulses, inclusive of READ/WAIT/EMIT.

Reset
REQ-013 rstn low asynchronously forces IDLE, counters to 0, and tile_valid=0, done=0, busy=0, bram_addr=0, tile_id=0, tile_x=0, tile_y=0; a scan interrupted by reset is abandoned, not resumed.

Configuration
REQ-014 MAP_ANIM_EN defined: a 1-bit phase register, reset 0, toggles on each done; sprite-sourced tile ids are XORed with the phase in bit 0. Undefined: no phase register, sprite ids pass unmodified. BRAM-sourced ids are never modified.

Structure
REQ-015 Shared package holds default MAP_W/MAP_H, TILE_BITS, ADDR_BITS, GRID_BITS, and the FSM state encoding.
REQ-016 Sub-module spr_overlay (combinational priority match over NUM_SPR channels) is instantiated once.

Verification
REQ-017 map_id=2, no sprites, ready=1, BRAM returns addr[15:0] -> tile (0,0) id 338, tile (12,12) id 506, 169 tiles, done once.
REQ-018 Channel 0 and channel 2 both enabled at (3,4), tiles 0x10/0x20 -> tile (3,4) id 0x10; channel 0 disabled -> 0x20.
REQ-019 tile_ready low for 5 cycles at tile (5,0) -> tile_valid and data stable all 5 cycles, no tile skipped or duplicated.
REQ-020 start pulsed mid-scan, sprite inputs changed mid-scan -> 169 tiles only, sprites from original snapshot.
REQ-021 rstn asserted at tile 50 -> outputs at reset values immediately; new start -> scan restarts at (0,0).
REQ-022 MAP_ANIM_EN defined, sprite tile 0x10, two frames -> frame 1 id 0x10, frame 2 id 0x11; undefined -> 0x10 both.
